// File: rtl/phase_ramp_generator.sv
// phase_ramp_generator
//   Phase accumulator (NCO) feeding the sin/cos lookup. The increment
//   (rotation speed) is either loaded directly or slewed exponentially
//   toward a commanded target so the rotation speed changes smoothly.
//
// Ports
//   clk, resetN          clock (rising edge), async active-low reset
//   enable               advance accumulator and slew this cycle
//   cmdValid/cmdReady    increment command handshake
//   cmdIncrement         signed target increment
//   cmdImmediate         1: load directly, 0: slew toward it
//   phase                top phaseBits of the accumulator (registered)
//   increment            signed current increment (registered)
//   slewing              high while slewing toward the target
//   wrap                 one-cycle pulse when the accumulator crosses 2^accBits
//   revCount             signed revolution count (only with PHASE_REVCOUNT_EN)
//
// Build option: define PHASE_REVCOUNT_EN to add the revCount port and counter.
module phase_ramp_generator #(
  parameter int unsigned phaseBits = 16,
  parameter int unsigned accBits   = 24,
  parameter int unsigned slewShift = 4,
  parameter int unsigned revBits   = 16
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 enable,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  input  logic [accBits-1:0]   cmdIncrement,
  input  logic                 cmdImmediate,
  output logic [phaseBits-1:0] phase,
  output logic [accBits-1:0]   increment,
  output logic                 slewing,
  output logic                 wrap
`ifdef PHASE_REVCOUNT_EN
  ,
  output logic [revBits-1:0]   revCount
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SLEW = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [accBits-1:0]   acc_q, acc_d;
  logic [accBits-1:0]   inc_q, inc_d;
  logic [accBits-1:0]   target_q, target_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 slewing_q, slewing_d;
  logic                 wrap_q, wrap_d;

  logic [accBits:0]        sum;
  logic signed [accBits:0] diff;
  logic signed [accBits:0] step;
  logic [accBits:0]        inc_wide;
  logic                    slew_done;

`ifdef PHASE_REVCOUNT_EN
  logic [revBits-1:0] rev_q, rev_d;
`endif

  always_comb begin
    // Carry out of the unsigned sum; XOR with the increment sign turns it
    // into a wrap flag valid for both rotation directions.
    sum    = {1'b0, acc_q} + {1'b0, inc_q};
    acc_d  = acc_q;
    wrap_d = 1'b0;
    if (enable) begin
      acc_d  = sum[accBits-1:0];
      wrap_d = sum[accBits] ^ inc_q[accBits-1];
    end

    // Slew step at accBits+1 bits so target-increment cannot overflow.
    // A zero step is forced to +/-1 so the slew always terminates exactly.
    diff = {target_q[accBits-1], target_q} - {inc_q[accBits-1], inc_q};
    step = diff >>> slewShift;
    if (step == '0) begin
      step = diff[accBits] ? '1 : (accBits+1)'(1);
    end
    inc_wide  = {inc_q[accBits-1], inc_q} + step;
    slew_done = (inc_wide == {target_q[accBits-1], target_q});

    state_d  = state_q;
    inc_d    = inc_q;
    target_d = target_q;
    unique case (state_q)
      IDLE: begin
        if (cmdValid && cmd_ready_q) begin
          if (cmdImmediate || (cmdIncrement == inc_q)) begin
            inc_d = cmdIncrement;
          end else begin
            target_d = cmdIncrement;
            state_d  = SLEW;
          end
        end
      end
      SLEW: begin
        if (enable) begin
          inc_d = inc_wide[accBits-1:0];
          if (slew_done) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    slewing_d   = (state_d == SLEW);
  end

`ifdef PHASE_REVCOUNT_EN
  // Direction follows the increment that produced the wrap.
  always_comb begin
    rev_d = rev_q;
    if (wrap_d) begin
      rev_d = inc_q[accBits-1] ? rev_q - revBits'(1) : rev_q + revBits'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      inc_q       <= '0;
      target_q    <= '0;
      cmd_ready_q <= 1'b1;
      slewing_q   <= 1'b0;
      wrap_q      <= 1'b0;
`ifdef PHASE_REVCOUNT_EN
      rev_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      inc_q       <= inc_d;
      target_q    <= target_d;
      cmd_ready_q <= cmd_ready_d;
      slewing_q   <= slewing_d;
      wrap_q      <= wrap_d;
`ifdef PHASE_REVCOUNT_EN
      rev_q       <= rev_d;
`endif
    end
  end

  assign phase     = acc_q[accBits-1 -: phaseBits];
  assign increment = inc_q;
  assign cmdReady  = cmd_ready_q;
  assign slewing   = slewing_q;
  assign wrap      = wrap_q;
`ifdef PHASE_REVCOUNT_EN
  assign revCount  = rev_q;
`endif

endmodule

// File: tb/tb_phase_ramp_generator.sv
module tb_phase_ramp_generator;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        enable = 1'b0;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [23:0] cmdIncrement = '0;
  logic        cmdImmediate = 1'b0;
  logic [15:0] phase;
  logic [23:0] increment;
  logic        slewing;
  logic        wrap;
`ifdef PHASE_REVCOUNT_EN
  logic [15:0] revCount;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  phase_ramp_generator #(
    .phaseBits(16),
    .accBits  (24),
    .slewShift(4),
    .revBits  (16)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .enable      (enable),
    .cmdValid    (cmdValid),
    .cmdReady    (cmdReady),
    .cmdIncrement(cmdIncrement),
    .cmdImmediate(cmdImmediate),
    .phase       (phase),
    .increment   (increment),
    .slewing     (slewing),
    .wrap        (wrap)
`ifdef PHASE_REVCOUNT_EN
    ,
    .revCount    (revCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        valid;
    logic        imm;
    logic [23:0] cmd;
    logic [15:0] ph;
    logic [23:0] inc;
    logic        rdy;
    logic        slw;
    logic        wrp;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic valid, input logic imm,
                              input logic [23:0] cmd, input logic [15:0] ph,
                              input logic [23:0] inc, input logic rdy,
                              input logic slw, input logic wrp);
    vec_t v;
    v.en = en; v.valid = valid; v.imm = imm; v.cmd = cmd;
    v.ph = ph; v.inc = inc; v.rdy = rdy; v.slw = slw; v.wrp = wrp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic en, input logic v, input logic im, input logic [23:0] c);
    @(negedge clk);
    enable = en; cmdValid = v; cmdImmediate = im; cmdIncrement = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string nm, input logic [15:0] ph, input logic [23:0] inc,
                            input logic rdy, input logic slw, input logic wrp);
    chk({nm, ".phase"}, 32'(phase), 32'(ph));
    chk({nm, ".increment"}, 32'(increment), 32'(inc));
    chk({nm, ".cmdReady"}, 32'(cmdReady), 32'(rdy));
    chk({nm, ".slewing"}, 32'(slewing), 32'(slw));
    chk({nm, ".wrap"}, 32'(wrap), 32'(wrp));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    resetN = 1'b0; enable = 1'b0; cmdValid = 1'b0; cmdImmediate = 1'b0; cmdIncrement = '0;
    @(posedge clk);
    #1;
    check_outs("reset", 16'h0, 24'h0, 1'b1, 1'b0, 1'b0);
`ifdef PHASE_REVCOUNT_EN
    chk("reset.revCount", 32'(revCount), 32'h0);
`endif
    @(negedge clk);
    resetN = 1'b1;
  endtask

  vec_t tbl[15];

  int          up_hand[13] = '{4, 7, 10, 13, 16, 19, 21, 23, 25, 27, 29, 31, 33};
  int          down_hand[17] = '{60, 56, 52, 48, 45, 42, 39, 36, 33, 30, 28, 26, 24, 22, 20, 18, 16};
  int          up_seq[$];
  int          down_seq[$];
  logic [23:0] acc_m;
  logic [23:0] inc_m;
  logic        last;

  initial begin
    // One row per clock edge starting from reset; phase/wrap show the
    // accumulator update made with the increment held before that edge.
    tbl[0]  = mk(1'b1, 1'b1, 1'b1, 24'h000100, 16'h0000, 24'h000100, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 24'h000000, 16'h0001, 24'h000100, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 24'h000000, 16'h0002, 24'h000100, 1'b1, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 24'h000000, 16'h0002, 24'h000100, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b1, 24'hFFFF00, 16'h0003, 24'hFFFF00, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 24'h000000, 16'h0002, 24'hFFFF00, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 24'h000000, 16'h0001, 24'hFFFF00, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 24'h000000, 16'h0000, 24'hFFFF00, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 24'h000000, 16'hFFFF, 24'hFFFF00, 1'b1, 1'b0, 1'b1);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 24'h000000, 16'hFFFE, 24'hFFFF00, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b1, 1'b1, 24'h000000, 16'hFFFD, 24'h000000, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 24'h000000, 16'hFFFD, 24'h000000, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 1'b1, 1'b1, 24'h010000, 16'hFFFD, 24'h010000, 1'b1, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 24'h000000, 16'h00FD, 24'h010000, 1'b1, 1'b0, 1'b1);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 24'h010000, 16'h00FD, 24'h010000, 1'b1, 1'b0, 1'b0);

    foreach (up_hand[i]) up_seq.push_back(up_hand[i]);
    for (int v = 34; v <= 64; v++) up_seq.push_back(v);
    foreach (down_hand[i]) down_seq.push_back(down_hand[i]);
    for (int v = 15; v >= 0; v--) down_seq.push_back(v);

    repeat (2) @(posedge clk);

    // Table-driven vectors
    reset_dut();
    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].en, tbl[i].valid, tbl[i].imm, tbl[i].cmd);
      check_outs($sformatf("vec%0d", i), tbl[i].ph, tbl[i].inc, tbl[i].rdy, tbl[i].slw, tbl[i].wrp);
    end
`ifdef PHASE_REVCOUNT_EN
    chk("vec.revCount_net", 32'(revCount), 32'h0);
`endif

    // Reverse rotation from zero wraps on the first step
    reset_dut();
    tick(1'b1, 1'b1, 1'b1, 24'hFFFF00);
    check_outs("rev.load", 16'h0000, 24'hFFFF00, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 24'h0);
    check_outs("rev.first", 16'hFFFF, 24'hFFFF00, 1'b1, 1'b0, 1'b1);
`ifdef PHASE_REVCOUNT_EN
    chk("rev.revCount", 32'(revCount), 32'h0000FFFF);
`endif

    // Slew up to 0x40 while a zero command is held pending
    reset_dut();
    acc_m = '0; inc_m = '0;
    tick(1'b1, 1'b1, 1'b0, 24'h000040);
    check_outs("slew.accept", acc_m[23:8], 24'h0, 1'b0, 1'b1, 1'b0);
    foreach (up_seq[i]) begin
      tick(1'b1, 1'b1, 1'b0, 24'h0);
      acc_m = acc_m + inc_m;
      inc_m = 24'(up_seq[i]);
      last  = (up_seq[i] == 64);
      check_outs($sformatf("up%0d", i), acc_m[23:8], inc_m, last, !last, 1'b0);
    end
    // Pending zero command taken on the first cycle cmdReady is high
    tick(1'b1, 1'b1, 1'b0, 24'h0);
    acc_m = acc_m + inc_m;
    check_outs("down.accept", acc_m[23:8], 24'h000040, 1'b0, 1'b1, 1'b0);
    foreach (down_seq[i]) begin
      tick(1'b1, 1'b0, 1'b0, 24'h0);
      acc_m = acc_m + inc_m;
      inc_m = 24'(down_seq[i]);
      last  = (down_seq[i] == 0);
      check_outs($sformatf("down%0d", i), acc_m[23:8], inc_m, last, !last, 1'b0);
      if (i == 4) begin
        for (int k = 0; k < 10; k++) begin
          tick(1'b0, 1'b0, 1'b0, 24'h0);
          check_outs($sformatf("freeze%0d", k), acc_m[23:8], inc_m, 1'b0, 1'b1, 1'b0);
        end
      end
    end

    // Async reset mid-slew takes effect before the next clock edge
    reset_dut();
    tick(1'b1, 1'b1, 1'b0, 24'h000040);
    tick(1'b1, 1'b0, 1'b0, 24'h0);
    tick(1'b1, 1'b0, 1'b0, 24'h0);
    check_outs("mid.pre", 16'h0000, 24'd7, 1'b0, 1'b1, 1'b0);
    #2 resetN = 1'b0;
    #1 check_outs("mid.reset", 16'h0, 24'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 24'h0);
    check_outs("mid.after", 16'h0, 24'h0, 1'b1, 1'b0, 1'b0);

    // Full forward revolution at 0x100 per cycle
    reset_dut();
    tick(1'b1, 1'b1, 1'b1, 24'h000100);
    check_outs("rev1.load", 16'h0, 24'h000100, 1'b1, 1'b0, 1'b0);
    for (int unsigned k = 1; k <= 65537; k++) begin
      tick(1'b1, 1'b0, 1'b0, 24'h0);
      chk("rev1.phase", 32'(phase), 32'(k[15:0]));
      chk("rev1.wrap", 32'(wrap), 32'(k == 65536));
    end
`ifdef PHASE_REVCOUNT_EN
    chk("rev1.revCount", 32'(revCount), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
